cond_unit: RTL
==============

# cond_unit

Conditional-execution unit for the single-cycle processor datapath. It is the consumer of the ALU's 4-bit `ALUFlags` output. It holds the architectural NZCV flag register, updated per the decoder's `FlagW` group enables. Each cycle it evaluates the instruction's 4-bit condition field against the stored flags, gates the decoder's `PCS`/`RegW`/`MemW` strobes into `PCSrc`/`RegWrite`/`MemWrite`, and counts squashed (condition-failed) instructions for debug.

## Interface
- `BYPASS`, default 0: 1 makes evaluation use flags written in the same cycle; 0 evaluates against stored flags only.
- `CNT_W`, default 8: width of the squash counter.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: instruction valid this cycle. When 0, no flag update, no count, all gated strobes 0.
- `Cond` in 4: instruction condition field.
- `ALUFlags` in 4: flags from the ALU. [3]=N, [2]=Z, [1]=C, [0]=V.
- `FlagW` in 2: [1] writes N,Z; [0] writes C,V.
- `PCS` in 1: decoder branch/PC-write strobe.
- `RegW` in 1: decoder register-write strobe.
- `MemW` in 1: decoder memory-write strobe.
- `NoWrite` in 1: compare-class instruction. Suppresses `RegWrite` only.
- `cnt_clr` in 1: synchronous clear of the squash counter.
- `PCSrc` out 1: gated `PCS`.
- `RegWrite` out 1: gated `RegW`.
- `MemWrite` out 1: gated `MemW`.
- `CondEx` out 1: condition passed and `en`=1.
- `Flags` out 4: stored NZCV register, same bit order as `ALUFlags`.
- `squash_cnt` out `CNT_W`: saturating count of condition-failed instructions.

## Operation
- **Evaluation flags `F`:**
  - `BYPASS`=0: `F` = `Flags`.
  - `BYPASS`=1: N,Z come from `ALUFlags` when `FlagW[1]`, else from `Flags`. C,V come from `ALUFlags` when `FlagW[0]`, else from `Flags`.
- **Condition decode (`pass`):**
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: !Z&C. 1001 LS: Z|!C.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 0 (never; reserved encoding squashes).
- **Gated outputs:**
  - `CondEx` = `en` & `pass`.
  - `PCSrc` = `PCS` & `CondEx`.
  - `MemWrite` = `MemW` & `CondEx`.
  - `RegWrite` = `RegW` & `CondEx` & !`NoWrite`.
- **Flag update:** only when `CondEx`=1.
  - `FlagW[1]` loads `Flags[3:2]` <= `ALUFlags[3:2]`.
  - `FlagW[0]` loads `Flags[1:0]` <= `ALUFlags[1:0]`.
  - The two groups are independent; an unselected group holds.
  - A failed condition never modifies flags, regardless of `FlagW`.
- **Squash counter:**
  - `cnt_clr`=1 sets it to 0. Clear has priority over increment in the same cycle.
  - Otherwise it increments by 1 when `en`=1 and `pass`=0.
  - It saturates at all-ones; no wrap-around.
  - `en`=0 cycles are never counted.
- `ALUFlags` bits outside the selected `FlagW` groups are ignored. Flag bits are stored unmodified; no width arithmetic.

## Timing
- **Combinational paths:** `CondEx`, `PCSrc`, `RegWrite` and `MemWrite` are combinational from `Cond`, `en`, the strobes and `F`.
  - With `BYPASS`=1 this includes a path from `ALUFlags` and `FlagW`.
- **Update latency:** `Flags` and `squash_cnt` update on the rising `clk` edge.
  - An instruction setting flags in cycle k is visible to the condition check in cycle k+1 with 1-cycle latency (`BYPASS`=0).
- **Reset:** `rst_n` low asynchronously forces `Flags`=4'b0000 and `squash_cnt`=0.
  - During reset the gated outputs follow the combinational rules with `F`=0, so `en`=1 with EQ fails.
  - Reset asserted mid-operation discards the pending update for that edge.
  - Reset release is synchronous to the next `clk` edge; the first update occurs no earlier than that edge.
- **Stable inputs:** with `en`=0 held, all registers are frozen indefinitely (except `cnt_clr`).

## Test plan
- **Reset / EQ on zero flags:** hold `rst_n`=0, then release; `Cond`=0000, `en`=1, `RegW`=1.
  - Required: `Flags`=0000, `CondEx`=0, `RegWrite`=0, `squash_cnt`=1 after one edge.
- **Compare then branch:** cycle k: `Cond`=1110, `FlagW`=11, `ALUFlags`=0110 (Z=1, C=1), `NoWrite`=1, `RegW`=1.
  - Required in cycle k: `RegWrite`=0.
  - Required in k+1: `Flags`=0110; `Cond`=0000 with `PCS`=1 gives `PCSrc`=1; `Cond`=1000 (HI) gives `CondEx`=0.
- **Partial update:** `Flags`=1001, `FlagW`=10, `ALUFlags`=0110, `Cond`=1110.
  - Required: `Flags`=0101 next cycle (C,V retained).
- **Failed condition blocks writes:** `Flags`=0000, `Cond`=0000, `FlagW`=11, `ALUFlags`=1111, `MemW`=1.
  - Required: `MemWrite`=0, `Flags` stays 0000, `squash_cnt` +1.
- **Signed compares:** `Flags`=1000 (N=1, V=0).
  - Required: GE fails, LT passes, GT fails, LE passes.
  - `Flags`=1001: GE and GT pass.
  - `Cond`=1111 fails under all flag values.
- **Counter bounds:** with `CNT_W`=8, issue 300 failing instructions.
  - Required: `squash_cnt`=255 and holds.
  - `cnt_clr`=1 concurrent with a failing instruction gives 0.
  - Repeat with `BYPASS`=1: a same-cycle `FlagW`=10, `ALUFlags`=0100 with `Cond`=0000 passes immediately.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flag register, checks the
// instruction condition, gates the decoder's write strobes and counts squashed instructions.
module cond_unit #(
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             cnt_clr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0] f;
  logic       n, z, c, v;
  logic       pass;

  // With BYPASS, flag groups written this cycle feed straight into the condition check.
  always_comb begin
    f = Flags;
    if (BYPASS) begin
      if (FlagW[1]) f[3:2] = ALUFlags[3:2];
      if (FlagW[0]) f[1:0] = ALUFlags[1:0];
    end
  end

  assign n = f[3];
  assign z = f[2];
  assign c = f[1];
  assign v = f[0];

  always_comb begin
    pass = 1'b0;
    case (Cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = !z && c;
      4'b1001: pass = z || !c;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z && (n == v);
      4'b1101: pass = z || (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign CondEx   = en & pass;
  assign PCSrc    = PCS & CondEx;
  assign MemWrite = MemW & CondEx;
  assign RegWrite = RegW & CondEx & !NoWrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Flags <= 4'b0000;
    end else if (CondEx) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Saturating squash counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt <= '0;
    end else if (cnt_clr) begin
      squash_cnt <= '0;
    end else if (en && !pass && (squash_cnt != {CNT_W{1'b1}})) begin
      squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end

endmodule
